// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and constants for the Ex-stage hazard controller.
package ex_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ERR      = 2'd3
   } hz_state_e;

   localparam logic [1:0] FWD_REG   = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Ex/Mem wins over Mem/WB; a load in Ex/Mem has no ALU result to forward yet.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic [4:0] rd_ex,
      input logic       wr_ex,
      input logic       ld_ex,
      input logic [4:0] rd_mem,
      input logic       wr_mem
   );
      if (wr_ex && rd_ex != REG_ZERO && rd_ex == src && !ld_ex)
         return FWD_EXMEM;
      else if (wr_mem && rd_mem != REG_ZERO && rd_mem == src)
         return FWD_MEMWB;
      else
         return FWD_REG;
   endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-controller bus: ID/Ex/Mem stage state in, pipeline control out.
interface ex_hazard_ctrl_if;

   logic [4:0] rs_id;
   logic [4:0] rt_id;
   logic       use_rs_id;
   logic       use_rt_id;
   logic [4:0] regwr_ex;
   logic       REGWR_ex;
   logic       MEM2REG_ex;
   logic [4:0] regwr_mem;
   logic       REGWR_mem;
   logic       redirect_mem;
   logic       mem_req;
   logic       mem_ready;

   logic [1:0] fwdA;
   logic [1:0] fwdB;
   logic       stall_pc;
   logic       stall_id;
   logic       bubble_ex;
   logic       flush_id;
   logic       freeze;
   logic       mem_err;

   modport master (
      output rs_id, rt_id, use_rs_id, use_rt_id, regwr_ex, REGWR_ex, MEM2REG_ex,
             regwr_mem, REGWR_mem, redirect_mem, mem_req, mem_ready,
      input  fwdA, fwdB, stall_pc, stall_id, bubble_ex, flush_id, freeze, mem_err
   );

   modport slave (
      input  rs_id, rt_id, use_rs_id, use_rt_id, regwr_ex, REGWR_ex, MEM2REG_ex,
             regwr_mem, REGWR_mem, redirect_mem, mem_req, mem_ready,
      output fwdA, fwdB, stall_pc, stall_id, bubble_ex, flush_id, freeze, mem_err
   );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_unit.sv
// Combinational ALU operand-forwarding selects for both Ex operands.
module ex_fwd_unit
   import ex_hazard_ctrl_pkg::*;
(
   input  logic [4:0] rs_id,
   input  logic [4:0] rt_id,
   input  logic [4:0] regwr_ex,
   input  logic       REGWR_ex,
   input  logic       MEM2REG_ex,
   input  logic [4:0] regwr_mem,
   input  logic       REGWR_mem,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   assign fwd_a = fwd_sel(rs_id, regwr_ex, REGWR_ex, MEM2REG_ex, regwr_mem, REGWR_mem);
   assign fwd_b = fwd_sel(rt_id, regwr_ex, REGWR_ex, MEM2REG_ex, regwr_mem, REGWR_mem);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Ex-stage pipeline sequencer: reset hold, load-use stall, redirect flush, memory freeze/timeout.
// Optional HAZ_PERF_CNT_EN adds saturating lu_cnt / wait_cnt / flush_cnt outputs.
module ex_hazard_ctrl
   import ex_hazard_ctrl_pkg::*;
#(
   parameter int RST_HOLD    = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef HAZ_PERF_CNT_EN
   output logic [15:0] lu_cnt,
   output logic [15:0] wait_cnt,
   output logic [15:0] flush_cnt,
`endif
   ex_hazard_ctrl_if.slave hz
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD == 0 ? 0 : RST_HOLD - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(MEM_TIMEOUT - 1);

   hz_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             mem_err_q, err_nxt;
   logic             stall, bubble, flush, freeze;
   logic             lu, lu_stall, rd_flush;
   logic [1:0]       fwd_a_raw, fwd_b_raw;

   ex_fwd_unit u_fwd (
      .rs_id      (hz.rs_id),
      .rt_id      (hz.rt_id),
      .regwr_ex   (hz.regwr_ex),
      .REGWR_ex   (hz.REGWR_ex),
      .MEM2REG_ex (hz.MEM2REG_ex),
      .regwr_mem  (hz.regwr_mem),
      .REGWR_mem  (hz.REGWR_mem),
      .fwd_a      (fwd_a_raw),
      .fwd_b      (fwd_b_raw)
   );

   assign lu = hz.MEM2REG_ex && hz.REGWR_ex && (hz.regwr_ex != REG_ZERO) &&
               ((hz.use_rs_id && hz.rs_id == hz.regwr_ex) ||
                (hz.use_rt_id && hz.rt_id == hz.regwr_ex));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= HOLD;
         cnt       <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         mem_err_q <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = mem_err_q;
      stall     = 1'b0;
      bubble    = 1'b0;
      flush     = 1'b0;
      freeze    = 1'b0;
      lu_stall  = 1'b0;
      rd_flush  = 1'b0;
      if (!rst_n) begin
         stall     = 1'b1;
         bubble    = 1'b1;
         state_nxt = HOLD;
         cnt_nxt   = '0;
         err_nxt   = 1'b0;
      end else begin
         unique case (state)
            HOLD: begin
               stall  = 1'b1;
               bubble = 1'b1;
               if (RST_HOLD == 0 || cnt == HOLD_LAST) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            RUN: begin
               // A stalled memory access keeps the redirecting instruction in Mem,
               // so the freeze is checked before the redirect.
               if (hz.mem_req && !hz.mem_ready) begin
                  freeze    = 1'b1;
                  stall     = 1'b1;
                  state_nxt = MEM_WAIT;
                  cnt_nxt   = CNT_ONE;
               end else if (hz.redirect_mem) begin
                  flush    = 1'b1;
                  bubble   = 1'b1;
                  rd_flush = 1'b1;
               end else if (lu) begin
                  stall    = 1'b1;
                  bubble   = 1'b1;
                  lu_stall = 1'b1;
               end
            end
            MEM_WAIT: begin
               freeze = 1'b1;
               stall  = 1'b1;
               if (hz.mem_ready) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else if (cnt == TO_LAST) begin
                  state_nxt = ERR;
                  err_nxt   = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            ERR: begin
               freeze  = 1'b1;
               stall   = 1'b1;
               err_nxt = 1'b1;
            end
            default: state_nxt = HOLD;
         endcase
      end
   end

   assign hz.fwdA      = rst_n ? fwd_a_raw : FWD_REG;
   assign hz.fwdB      = rst_n ? fwd_b_raw : FWD_REG;
   assign hz.stall_pc  = stall;
   assign hz.stall_id  = stall;
   assign hz.bubble_ex = bubble;
   assign hz.flush_id  = flush;
   assign hz.freeze    = freeze;
   assign hz.mem_err   = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lu_cnt    <= '0;
         wait_cnt  <= '0;
         flush_cnt <= '0;
      end else begin
         if (lu_stall && lu_cnt != 16'hFFFF)           lu_cnt    <= lu_cnt + 16'd1;
         if (state == MEM_WAIT && wait_cnt != 16'hFFFF) wait_cnt  <= wait_cnt + 16'd1;
         if (rd_flush && flush_cnt != 16'hFFFF)        flush_cnt <= flush_cnt + 16'd1;
      end
   end
`else
   logic unused_perf;
   assign unused_perf = lu_stall ^ rd_flush;
`endif

endmodule
